audio_flt_cfg: RTL and testbench

//  Filter-configuration sequencer for the audio output path. Buffers 16-bit register writes from the HPS

---
 rtl/audio_flt_cfg.sv | 253 +++++++++++++++++++++++++
 tb/tb_audio_flt_cfg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_flt_cfg.sv
// audio_flt_cfg: filter-configuration sequencer for the audio output path.
//
// HPS register writes land in a shadow coefficient/rate set. A commit write
// (addr 15) mutes the core audio path, waits MUTE_SAMPLES sample strobes for
// the IIR pipeline to drain, copies the whole shadow set into the active
// outputs in a single clock, then holds mute for SETTLE_SAMPLES strobes while
// the filter settles.
//
// Build option: define AUDIO_FLT_CFG_READBACK_EN to build the registered
// shadow readback on rd_data; otherwise rd_data is tied to zero.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   sample_ce           one-cycle audio sample strobe
//   wr, addr, din       16-bit register write port (one cycle per word)
//   flt_rate, cx, cx0..cx2, cy0..cy2   active filter configuration
//   cfg_valid           set once the first commit has been applied
//   mute                forces core audio to zero in the mixer
//   busy                commit sequence in progress
//   rd_data             shadow readback (readback build only, else 0)

module audio_flt_cfg #(
    parameter int unsigned MUTE_SAMPLES   = 16,
    parameter int unsigned SETTLE_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_ce,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [15:0] din,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic        cfg_valid,
    output logic        mute,
    output logic        busy,
    output logic [15:0] rd_data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] MUTE_CNT   = CNT_W'(MUTE_SAMPLES);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    localparam logic [3:0] A_RATE_LO = 4'd0;
    localparam logic [3:0] A_RATE_HI = 4'd1;
    localparam logic [3:0] A_CX_LO   = 4'd2;
    localparam logic [3:0] A_CX_MID  = 4'd3;
    localparam logic [3:0] A_CX_HI   = 4'd4;
    localparam logic [3:0] A_CX10    = 4'd5;
    localparam logic [3:0] A_CX2     = 4'd6;
    localparam logic [3:0] A_CY0_LO  = 4'd7;
    localparam logic [3:0] A_CY0_HI  = 4'd8;
    localparam logic [3:0] A_CY1_LO  = 4'd9;
    localparam logic [3:0] A_CY1_HI  = 4'd10;
    localparam logic [3:0] A_CY2_LO  = 4'd11;
    localparam logic [3:0] A_CY2_HI  = 4'd12;
    localparam logic [3:0] A_COMMIT  = 4'd15;

    // One complete filter configuration; shadow and active use the same layout.
    typedef struct packed {
        logic [31:0] rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coef_set_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    coef_set_t        shadow_q, shadow_d;
    coef_set_t        active_q, active_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;

    logic             commit_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Sequencer next state, shadow write decode and swap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        cfg_valid_d = cfg_valid_q;

        commit_c  = wr && (addr == A_COMMIT);
        // Saturating count so a long run never wraps back to a match.
        cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        // A commit arriving mid-sequence is remembered for the next run.
        if (commit_c) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // A commit in IDLE starts at once so mute follows one cycle later.
                if (pending_q || commit_c) begin
                    state_d   = DRAIN;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            DRAIN: begin
                if (cnt_q == MUTE_CNT) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (sample_ce) begin
                    cnt_d = cnt_inc_c;
                end
            end
            LOAD: begin
                // Registered shadow is the pre-write value if a write lands now.
                active_d    = shadow_q;
                cfg_valid_d = 1'b1;
                state_d     = SETTLE;
                cnt_d       = '0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sample_ce) begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (wr) begin
            case (addr)
                A_RATE_LO: shadow_d.rate[15:0]  = din;
                A_RATE_HI: shadow_d.rate[31:16] = din;
                A_CX_LO:   shadow_d.cx[15:0]    = din;
                A_CX_MID:  shadow_d.cx[31:16]   = din;
                A_CX_HI:   shadow_d.cx[39:32]   = din[7:0];
                A_CX10: begin
                    shadow_d.cx0 = din[7:0];
                    shadow_d.cx1 = din[15:8];
                end
                A_CX2:     shadow_d.cx2         = din[7:0];
                A_CY0_LO:  shadow_d.cy0[15:0]   = din;
                A_CY0_HI:  shadow_d.cy0[23:16]  = din[7:0];
                A_CY1_LO:  shadow_d.cy1[15:0]   = din;
                A_CY1_HI:  shadow_d.cy1[23:16]  = din[7:0];
                A_CY2_LO:  shadow_d.cy2[15:0]   = din;
                A_CY2_HI:  shadow_d.cy2[23:16]  = din[7:0];
                default:   shadow_d             = shadow_q;
            endcase
        end

        // Mute/busy registered from the next state: high for every non-IDLE cycle.
        mute_d = (state_d != IDLE);
        busy_d = (state_d != IDLE);
    end

    // State and configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
            cfg_valid_q <= 1'b0;
            mute_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cfg_valid_q <= cfg_valid_d;
            mute_q      <= mute_d;
            busy_q      <= busy_d;
        end
    end

    assign flt_rate  = active_q.rate;
    assign cx        = active_q.cx;
    assign cx0       = active_q.cx0;
    assign cx1       = active_q.cx1;
    assign cx2       = active_q.cx2;
    assign cy0       = active_q.cy0;
    assign cy1       = active_q.cy1;
    assign cy2       = active_q.cy2;
    assign cfg_valid = cfg_valid_q;
    assign mute      = mute_q;
    assign busy      = busy_q;

`ifdef AUDIO_FLT_CFG_READBACK_EN
    logic [15:0] rd_data_q, rd_data_d;

    // Shadow readback mux; narrow fields are zero-extended.
    always_comb begin
        rd_data_d = {15'd0, busy_q};
        case (addr)
            A_RATE_LO: rd_data_d = shadow_q.rate[15:0];
            A_RATE_HI: rd_data_d = shadow_q.rate[31:16];
            A_CX_LO:   rd_data_d = shadow_q.cx[15:0];
            A_CX_MID:  rd_data_d = shadow_q.cx[31:16];
            A_CX_HI:   rd_data_d = {8'd0, shadow_q.cx[39:32]};
            A_CX10:    rd_data_d = {shadow_q.cx1, shadow_q.cx0};
            A_CX2:     rd_data_d = {8'd0, shadow_q.cx2};
            A_CY0_LO:  rd_data_d = shadow_q.cy0[15:0];
            A_CY0_HI:  rd_data_d = {8'd0, shadow_q.cy0[23:16]};
            A_CY1_LO:  rd_data_d = shadow_q.cy1[15:0];
            A_CY1_HI:  rd_data_d = {8'd0, shadow_q.cy1[23:16]};
            A_CY2_LO:  rd_data_d = shadow_q.cy2[15:0];
            A_CY2_HI:  rd_data_d = {8'd0, shadow_q.cy2[23:16]};
            default:   rd_data_d = {15'd0, busy_q};
        endcase
    end

    // Readback register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`else
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_audio_flt_cfg.sv
// tb_audio_flt_cfg: directed bench for audio_flt_cfg with a word-level
// reference model (shadow/active kept as arrays of 16-bit register words)
// compared against the DUT on every falling clock edge.

module tb_audio_flt_cfg;

    localparam int unsigned MUTE_N   = 2;
    localparam int unsigned SETTLE_N = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_ce = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] din = 16'd0;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic        cfg_valid, mute, busy;
    logic [15:0] rd_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit ce_en = 1'b0;
    int ce_div = 0;
    int rises = 0;
    logic mute_prev = 1'b0;

    audio_flt_cfg #(
        .MUTE_SAMPLES  (MUTE_N),
        .SETTLE_SAMPLES(SETTLE_N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sample_ce(sample_ce),
        .wr       (wr),
        .addr     (addr),
        .din      (din),
        .flt_rate (flt_rate),
        .cx       (cx),
        .cx0      (cx0),
        .cx1      (cx1),
        .cx2      (cx2),
        .cy0      (cy0),
        .cy1      (cy1),
        .cy2      (cy2),
        .cfg_valid(cfg_valid),
        .mute     (mute),
        .busy     (busy),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Sample strobe every 10 clocks.
    always @(negedge clk) begin
        if (ce_div == 9) ce_div = 0;
        else ce_div = ce_div + 1;
        sample_ce = ce_en && (ce_div == 9);
    end

    // ---------------- reference model ----------------
    logic [15:0] m_sh  [16];
    logic [15:0] m_act [16];
    int          m_phase;   // 0 idle, 1 muted before swap, 2 swap, 3 muted after swap
    int          m_seen;    // strobes seen in the current muted phase
    bit          m_pend, m_valid, m_busy;
    logic [15:0] m_rd;

    always @(posedge clk or negedge reset_n) begin
        bit c;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                m_sh[i]  = 16'd0;
                m_act[i] = 16'd0;
            end
            m_phase = 0; m_seen = 0; m_pend = 1'b0;
            m_valid = 1'b0; m_busy = 1'b0; m_rd = 16'd0;
        end else begin
            c = wr && (addr == 4'd15);
`ifdef AUDIO_FLT_CFG_READBACK_EN
            m_rd = (addr < 4'd13) ? m_sh[addr] : {15'd0, m_busy};
`else
            m_rd = 16'd0;
`endif
            if (m_phase == 0) begin
                if (c || m_pend) begin
                    m_phase = 1; m_seen = 0; m_pend = 1'b0;
                end
            end else begin
                if (c) m_pend = 1'b1;
                if (m_phase == 1) begin
                    if (m_seen == int'(MUTE_N)) m_phase = 2;
                    else if (sample_ce) m_seen++;
                end else if (m_phase == 2) begin
                    m_act   = m_sh;
                    m_valid = 1'b1;
                    m_phase = 3;
                    m_seen  = 0;
                end else begin
                    if (m_seen == int'(SETTLE_N)) m_phase = 0;
                    else if (sample_ce) m_seen++;
                end
            end
            m_busy = (m_phase != 0);
            if (wr && addr < 4'd13) begin
                if (addr inside {4'd4, 4'd6, 4'd8, 4'd10, 4'd12}) m_sh[addr] = {8'd0, din[7:0]};
                else m_sh[addr] = din;
            end
        end
    end

    function automatic logic [167:0] set_vec(input logic [15:0] w [16]);
        logic [15:0] w4, w5, w6, w8, w10, w12;
        w4 = w[4]; w5 = w[5]; w6 = w[6]; w8 = w[8]; w10 = w[10]; w12 = w[12];
        return {w[1], w[0], w4[7:0], w[3], w[2], w5[7:0], w5[15:8], w6[7:0],
                w8[7:0], w[7], w10[7:0], w[9], w12[7:0], w[11]};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [167:0] dv, ev;
        if (chk_en) begin
            checks++;
            if ({mute, busy, cfg_valid} !== {m_busy, m_busy, m_valid}) begin
                errors++;
                $display("FAIL ctrl t=%0t got mute/busy/valid=%b%b%b exp %b%b%b",
                         $time, mute, busy, cfg_valid, m_busy, m_busy, m_valid);
            end
            dv = {flt_rate, cx, cx0, cx1, cx2, cy0, cy1, cy2};
            ev = set_vec(m_act);
            checks++;
            if (dv !== ev) begin
                errors++;
                $display("FAIL active t=%0t got %h exp %h", $time, dv, ev);
            end
            checks++;
            if (rd_data !== m_rd) begin
                errors++;
                $display("FAIL rd_data t=%0t got %h exp %h", $time, rd_data, m_rd);
            end
        end
    end

    // Counts mute rising edges.
    always @(negedge clk) begin
        if (mute === 1'b1 && mute_prev === 1'b0) rises++;
        mute_prev = mute;
    end

    task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; din = d;
        @(negedge clk);
        wr = 1'b0; din = 16'd0;
    endtask

    task automatic wait_mute(input logic lvl, input int budget);
        int n;
        n = 0;
        while (mute !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mute !== lvl) begin
            errors++;
            $display("FAIL wait_mute got %b exp %b within %0d cycles", mute, lvl, budget);
        end
    endtask

    task automatic wait_ce(input int cnt, input int budget);
        int n, k;
        n = 0; k = 0;
        while (n < cnt && k < budget) begin
            @(posedge clk);
            if (sample_ce) n++;
            k++;
        end
        @(negedge clk);
        checks++;
        if (n < cnt) begin
            errors++;
            $display("FAIL wait_ce got %0d exp %0d strobes", n, cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        ce_en   = 1'b1;

        // 1: idle after reset
        repeat (1000) @(negedge clk);
        check_lit("idle_zero", 64'(|{mute, busy, cfg_valid, flt_rate, cx, cy0, cy1, cy2}), 64'd0);

        // 2: rate write and first commit
        wr_word(4'd0, 16'h7700);
        wr_word(4'd1, 16'h0001);
        wr_word(4'd15, 16'h0000);
        check_lit("mute_commit_plus1", 64'(mute), 64'd1);
        check_lit("rate_before_swap", 64'(flt_rate), 64'd0);
        wait_mute(1'b0, 300);
        check_lit("rate_after_seq", 64'(flt_rate), 64'h0000_0000_0001_7700);
        check_lit("cfg_valid_set", 64'(cfg_valid), 64'd1);

        // 3: write during SETTLE, visible only after the next commit
        wr_word(4'd15, 16'h0000);
        wait_mute(1'b1, 10);
        wait_ce(3, 100);
        wr_word(4'd9, 16'h3456);
        wr_word(4'd10, 16'hAB12);
        wait_mute(1'b0, 300);
        check_lit("cy1_unchanged", 64'(cy1), 64'd0);
        wr_word(4'd15, 16'h0000);
        wait_mute(1'b1, 10);
        wait_mute(1'b0, 300);
        check_lit("cy1_committed", 64'(cy1), 64'h12_3456);
        check_lit("rate_kept", 64'(flt_rate), 64'h0001_7700);

        // 4: two commits in DRAIN give exactly one extra sequence
        base = rises;
        wr_word(4'd15, 16'h0000);
        wait_mute(1'b1, 10);
        wr_word(4'd15, 16'h0000);
        wr_word(4'd15, 16'h0000);
        wait_mute(1'b0, 300);
        wait_mute(1'b1, 5);
        wait_mute(1'b0, 300);
        repeat (200) @(negedge clk);
        check_lit("seq_count", 64'(rises - base), 64'd2);

        // 5: asynchronous reset mid-DRAIN, then a full sequence
        wr_word(4'd15, 16'h0000);
        wait_mute(1'b1, 10);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_lit("async_reset", 64'(|{mute, busy, cfg_valid, flt_rate, cy1}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_word(4'd0, 16'h1234);
        wr_word(4'd15, 16'h0000);
        check_lit("mute_after_reset_commit", 64'(mute), 64'd1);
        wait_mute(1'b0, 300);
        check_lit("rate_after_reset", 64'(flt_rate), 64'h0000_1234);
        check_lit("cy1_after_reset", 64'(cy1), 64'd0);

        // 6: readback
        wr_word(4'd3, 16'hBEEF);
        @(negedge clk);
`ifdef AUDIO_FLT_CFG_READBACK_EN
        check_lit("rd_addr3", 64'(rd_data), 64'hBEEF);
        wr_word(4'd15, 16'h0000);
        @(negedge clk);
        check_lit("rd_addr15_busy", 64'(rd_data), 64'h0001);
        wait_mute(1'b0, 300);
`else
        check_lit("rd_tied0", 64'(rd_data), 64'd0);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
